// File: rtl/vga_pattern_gen_if.sv
// Pixel-domain bundle between the pattern generator and the board pins.
// The master side (the generator) reads mode and drives the colour, sync, enable and LED outputs.
interface vga_pattern_gen_if #(
  parameter int COLOR_BITS = 2
);
  logic [2:0]            mode;
  logic [COLOR_BITS-1:0] r;
  logic [COLOR_BITS-1:0] g;
  logic [COLOR_BITS-1:0] b;
  logic                  h_sync;
  logic                  v_sync;
  logic                  display_en;
  logic                  frame_start;
  logic                  led;

  modport master (
    input  mode,
    output r, g, b, h_sync, v_sync, display_en, frame_start, led
  );

  modport slave (
    output mode,
    input  r, g, b, h_sync, v_sync, display_en, frame_start, led
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator; all outputs registered one cycle after counter state.
// Free-running with no backpressure; mode and frame counter latch only on the last cycle of a frame.
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int COLOR_BITS = 2,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic              clk_in,
  input  logic              reset,
  vga_pattern_gen_if.master io_vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
  localparam logic [COLOR_BITS-1:0] FULL = '1;

  logic [HW-1:0]         r_h_cnt;
  logic [VW-1:0]         r_v_cnt;
  logic [2:0]            r_mode_q;
  logic [7:0]            r_frame_cnt;
  logic [COLOR_BITS-1:0] r_r;
  logic [COLOR_BITS-1:0] r_g;
  logic [COLOR_BITS-1:0] r_b;
  logic                  r_h_sync;
  logic                  r_v_sync;
  logic                  r_de;
  logic                  r_fs;

  logic [31:0]           w_x;
  logic [31:0]           w_y;
  logic [31:0]           w_bar_idx;
  logic [31:0]           w_bar_lo;
  logic [2:0]            w_bar_k;
  logic                  w_h_last;
  logic                  w_v_last;
  logic                  w_active;
  logic                  w_hs_act;
  logic                  w_vs_act;
  logic                  w_in_bar;
  logic [COLOR_BITS-1:0] w_r;
  logic [COLOR_BITS-1:0] w_g;
  logic [COLOR_BITS-1:0] w_b;

  // Widen the counters so pattern bit-picks and bounds work for any parameter set.
  assign w_x       = 32'(r_h_cnt);
  assign w_y       = 32'(r_v_cnt);
  assign w_h_last  = (w_x == 32'(H_TOTAL - 1));
  assign w_v_last  = (w_y == 32'(V_TOTAL - 1));
  assign w_active  = (w_x < 32'(H_ACTIVE)) && (w_y < 32'(V_ACTIVE));
  assign w_hs_act  = (w_x >= 32'(H_ACTIVE + H_FP)) && (w_x < 32'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vs_act  = (w_y >= 32'(V_ACTIVE + V_FP)) && (w_y < 32'(V_ACTIVE + V_FP + V_SYNC));
  assign w_bar_idx = w_x / 32'(BAR_W);
  assign w_bar_k   = (w_bar_idx > 32'd7) ? 3'd7 : w_bar_idx[2:0];
  assign w_bar_lo  = {22'd0, r_frame_cnt, 2'b00};
  assign w_in_bar  = (w_x >= w_bar_lo) && (w_x < (w_bar_lo + 32'd16));

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (w_active) begin
      case (r_mode_q)
        3'd1: begin
          w_r = FULL;
          w_g = FULL;
          w_b = FULL;
        end
        3'd2: begin
          w_r = w_bar_k[2] ? FULL : '0;
          w_g = w_bar_k[1] ? FULL : '0;
          w_b = w_bar_k[0] ? FULL : '0;
        end
        3'd3: begin
          if (w_x[5] ^ w_y[5]) begin
            w_r = FULL;
            w_g = FULL;
            w_b = FULL;
          end
        end
        3'd4: begin
          w_r = w_x[5 +: COLOR_BITS];
          w_g = w_x[5 +: COLOR_BITS];
          w_b = w_x[5 +: COLOR_BITS];
        end
        3'd5: begin
          if (w_in_bar) begin
            w_r = FULL;
            w_g = FULL;
            w_b = FULL;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_mode_q    <= 3'd0;
      r_frame_cnt <= 8'd0;
    end else begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        if (w_v_last) begin
          r_v_cnt     <= '0;
          r_mode_q    <= io_vga.mode;
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end else begin
          r_v_cnt <= r_v_cnt + 1'b1;
        end
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_r      <= '0;
      r_g      <= '0;
      r_b      <= '0;
      r_h_sync <= ~SYNC_POL;
      r_v_sync <= ~SYNC_POL;
      r_de     <= 1'b0;
      r_fs     <= 1'b0;
    end else begin
      r_r      <= w_r;
      r_g      <= w_g;
      r_b      <= w_b;
      r_h_sync <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_v_sync <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_de     <= w_active;
      r_fs     <= (r_h_cnt == '0) && (r_v_cnt == '0);
    end
  end

  assign io_vga.r           = r_r;
  assign io_vga.g           = r_g;
  assign io_vga.b           = r_b;
  assign io_vga.h_sync      = r_h_sync;
  assign io_vga.v_sync      = r_v_sync;
  assign io_vga.display_en  = r_de;
  assign io_vga.frame_start = r_fs;
  assign io_vga.led         = r_de;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen using three reduced-size instances sharing clock and reset.
// dut_m: 144x38 pattern checks; dut_s: 24x12 active-high sync timing; dut_t: 27x4 moving-bar wrap.
module tb_vga_pattern_gen;
  localparam int M_HT    = 144;
  localparam int M_FRAME = 144 * 38;
  localparam int S_FRAME = 24 * 12;
  localparam int T_FRAME = 27 * 4;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_in = ~clk_in;

  vga_pattern_gen_if #(.COLOR_BITS(2)) if_m ();
  vga_pattern_gen_if #(.COLOR_BITS(2)) if_s ();
  vga_pattern_gen_if #(.COLOR_BITS(2)) if_t ();

  vga_pattern_gen #(
    .H_ACTIVE(128), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(34), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .COLOR_BITS(2), .SYNC_POL(1'b0)
  ) dut_m (.clk_in(clk_in), .reset(reset), .io_vga(if_m));

  vga_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .COLOR_BITS(2), .SYNC_POL(1'b1)
  ) dut_s (.clk_in(clk_in), .reset(reset), .io_vga(if_s));

  vga_pattern_gen #(
    .H_ACTIVE(24), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .COLOR_BITS(2), .SYNC_POL(1'b0)
  ) dut_t (.clk_in(clk_in), .reset(reset), .io_vga(if_t));

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    reset = 1'b1;
  endtask

  task automatic wait_fs(input int sel, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      tick();
      if ((sel == 0 && if_m.frame_start === 1'b1) ||
          (sel == 1 && if_s.frame_start === 1'b1) ||
          (sel == 2 && if_t.frame_start === 1'b1))
        ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    if_m.mode = 3'd1;
    if_s.mode = 3'd1;
    if_t.mode = 3'd1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk_in);
    n_tests++;
    if ({if_m.r, if_m.g, if_m.b} !== 6'd0) begin n_fail++; $display("FAIL rst_rgb: got %b want 000000", {if_m.r, if_m.g, if_m.b}); end
    n_tests++;
    if (if_m.display_en !== 1'b0 || if_m.led !== 1'b0 || if_m.frame_start !== 1'b0) begin
      n_fail++; $display("FAIL rst_de_led_fs: got %b%b%b want 000", if_m.display_en, if_m.led, if_m.frame_start);
    end
    n_tests++;
    if (if_m.h_sync !== 1'b1 || if_m.v_sync !== 1'b1) begin n_fail++; $display("FAIL rst_sync_lowpol: got %b%b want 11", if_m.h_sync, if_m.v_sync); end
    n_tests++;
    if (if_s.h_sync !== 1'b0 || if_s.v_sync !== 1'b0) begin n_fail++; $display("FAIL rst_sync_highpol: got %b%b want 00", if_s.h_sync, if_s.v_sync); end
    reset = 1'b1;
    tick();
    n_tests++;
    if (if_m.frame_start !== 1'b1 || if_m.display_en !== 1'b1 || if_m.led !== 1'b1) begin
      n_fail++; $display("FAIL first_edge fs/de/led: got %b%b%b want 111", if_m.frame_start, if_m.display_en, if_m.led);
    end
    n_tests++;
    if ({if_m.r, if_m.g, if_m.b} !== 6'd0) begin n_fail++; $display("FAIL first_edge_black: got %b want 000000", {if_m.r, if_m.g, if_m.b}); end
    tick();
    n_tests++;
    if (if_m.frame_start !== 1'b0 || if_m.display_en !== 1'b1) begin
      n_fail++; $display("FAIL second_edge fs/de: got %b%b want 01", if_m.frame_start, if_m.display_en);
    end
  endtask

  task automatic test_timing_small();
    int fs_idx [3];
    int n_fs = 0;
    int hs_first = -1;
    int hs_cnt = 0;
    int vs_first = -1;
    int vs_cnt = 0;
    int de_cnt = 0;
    int n_rise = 0;
    int de_rise2 = -1;
    int col_bad = 0;
    int led_bad = 0;
    logic prev_de = 1'b0;
    if_s.mode = 3'd1;
    do_reset();
    for (int i = 0; i < 2 * S_FRAME + 4; i++) begin
      tick();
      if (if_s.frame_start === 1'b1 && n_fs < 3) begin fs_idx[n_fs] = i; n_fs++; end
      if (i < 24 && if_s.h_sync === 1'b1) begin if (hs_first < 0) hs_first = i; hs_cnt++; end
      if (i < S_FRAME) begin
        if (if_s.v_sync === 1'b1) begin if (vs_first < 0) vs_first = i; vs_cnt++; end
        if (if_s.display_en === 1'b1) de_cnt++;
      end
      if (if_s.display_en === 1'b1 && prev_de === 1'b0) begin n_rise++; if (n_rise == 2) de_rise2 = i; end
      prev_de = if_s.display_en;
      if (if_s.led !== if_s.display_en) led_bad++;
      if (i >= S_FRAME && i < 2 * S_FRAME) begin
        if ((if_s.display_en === 1'b1) ? ({if_s.r, if_s.g, if_s.b} !== 6'b111111) : ({if_s.r, if_s.g, if_s.b} !== 6'd0))
          col_bad++;
      end
    end
    n_tests++;
    if (n_fs != 3 || fs_idx[0] != 0 || fs_idx[1] != 288 || fs_idx[2] != 576) begin
      n_fail++; $display("FAIL fs_period: got n=%0d at %0d,%0d,%0d want 3 at 0,288,576", n_fs, fs_idx[0], fs_idx[1], fs_idx[2]);
    end
    n_tests++;
    if (hs_first != 18) begin n_fail++; $display("FAIL hsync_start: got %0d want 18", hs_first); end
    n_tests++;
    if (hs_cnt != 4) begin n_fail++; $display("FAIL hsync_width: got %0d want 4", hs_cnt); end
    n_tests++;
    if (vs_first != 216) begin n_fail++; $display("FAIL vsync_start: got %0d want 216", vs_first); end
    n_tests++;
    if (vs_cnt != 48) begin n_fail++; $display("FAIL vsync_width: got %0d want 48", vs_cnt); end
    n_tests++;
    if (de_cnt != 128) begin n_fail++; $display("FAIL de_count: got %0d want 128", de_cnt); end
    n_tests++;
    if (de_rise2 != 24) begin n_fail++; $display("FAIL line_period: got %0d want 24", de_rise2); end
    n_tests++;
    if (col_bad != 0) begin n_fail++; $display("FAIL white_frame: got %0d bad pixels want 0", col_bad); end
    n_tests++;
    if (led_bad != 0) begin n_fail++; $display("FAIL led_eq_de: got %0d mismatches want 0", led_bad); end
  endtask

  task automatic test_last_cycle();
    if_s.mode = 3'd0;
    do_reset();
    tick();
    repeat (286) tick();
    if_s.mode = 3'd1;
    tick();
    tick();
    n_tests++;
    if (if_s.frame_start !== 1'b1 || {if_s.r, if_s.g, if_s.b} !== 6'b111111) begin
      n_fail++; $display("FAIL last_cycle_capture: got fs=%b rgb=%b want fs=1 rgb=111111", if_s.frame_start, {if_s.r, if_s.g, if_s.b});
    end
    repeat (287) tick();
    if_s.mode = 3'd0;
    tick();
    n_tests++;
    if (if_s.frame_start !== 1'b1 || {if_s.r, if_s.g, if_s.b} !== 6'b111111) begin
      n_fail++; $display("FAIL too_late_ignored: got fs=%b rgb=%b want fs=1 rgb=111111", if_s.frame_start, {if_s.r, if_s.g, if_s.b});
    end
  endtask

  task automatic test_color_bars();
    int px [13];
    logic [5:0] exp_rgb [13];
    int j = 0;
    bit ok;
    bit ok2;
    px = '{0, 15, 16, 31, 47, 48, 64, 80, 96, 112, 127, 128, 140};
    exp_rgb = '{6'b00_00_00, 6'b00_00_00, 6'b00_00_11, 6'b00_00_11, 6'b00_11_00, 6'b00_11_11, 6'b11_00_00,
                6'b11_00_11, 6'b11_11_00, 6'b11_11_11, 6'b11_11_11, 6'b00_00_00, 6'b00_00_00};
    if_m.mode = 3'd2;
    do_reset();
    wait_fs(0, 4, ok);
    wait_fs(0, M_FRAME + 4, ok2);
    n_tests++;
    if (!(ok && ok2)) begin n_fail++; $display("FAIL bars_wait: got timeout want frame_start"); end
    for (int x = 0; x < M_HT; x++) begin
      if (x > 0) tick();
      if (j < 13 && x == px[j]) begin
        n_tests++;
        if ({if_m.r, if_m.g, if_m.b} !== exp_rgb[j] || if_m.display_en !== (x < 128)) begin
          n_fail++; $display("FAIL bars x=%0d: got rgb=%b de=%b want rgb=%b de=%b", x, {if_m.r, if_m.g, if_m.b}, if_m.display_en, exp_rgb[j], (x < 128));
        end
        j++;
      end
    end
  endtask

  task automatic test_mode_switch();
    bit ok;
    bit ok2;
    int bad = 0;
    int rx [6];
    logic [1:0] rv [6];
    int j = 0;
    rx = '{0, 31, 32, 64, 96, 127};
    rv = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    if_m.mode = 3'd1;
    do_reset();
    wait_fs(0, 4, ok);
    wait_fs(0, M_FRAME + 4, ok2);
    repeat (20 * M_HT) tick();
    n_tests++;
    if (!(ok && ok2) || {if_m.r, if_m.g, if_m.b} !== 6'b111111) begin
      n_fail++; $display("FAIL switch_pre (0,20): got ok=%b rgb=%b want ok=1 rgb=111111", ok && ok2, {if_m.r, if_m.g, if_m.b});
    end
    if_m.mode = 3'd3;
    ok = 1'b0;
    for (int i = 0; i < M_FRAME && !ok; i++) begin
      tick();
      if (if_m.frame_start === 1'b1) ok = 1'b1;
      else if (if_m.display_en === 1'b1 && {if_m.r, if_m.g, if_m.b} !== 6'b111111) bad++;
    end
    n_tests++;
    if (!ok || bad != 0) begin n_fail++; $display("FAIL switch_rest_white: got ok=%b bad=%0d want ok=1 bad=0", ok, bad); end
    n_tests++;
    if ({if_m.r, if_m.g, if_m.b} !== 6'd0) begin n_fail++; $display("FAIL checker (0,0): got %b want 000000", {if_m.r, if_m.g, if_m.b}); end
    repeat (32) tick();
    n_tests++;
    if ({if_m.r, if_m.g, if_m.b} !== 6'b111111) begin n_fail++; $display("FAIL checker (32,0): got %b want 111111", {if_m.r, if_m.g, if_m.b}); end
    repeat (32 * M_HT) tick();
    n_tests++;
    if ({if_m.r, if_m.g, if_m.b} !== 6'd0) begin n_fail++; $display("FAIL checker (32,32): got %b want 000000", {if_m.r, if_m.g, if_m.b}); end
    repeat (32) tick();
    n_tests++;
    if ({if_m.r, if_m.g, if_m.b} !== 6'b111111) begin n_fail++; $display("FAIL checker (64,32): got %b want 111111", {if_m.r, if_m.g, if_m.b}); end
    if_m.mode = 3'd4;
    wait_fs(0, M_FRAME + 4, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL ramp_wait: got timeout want frame_start"); end
    for (int x = 0; x < 128; x++) begin
      if (x > 0) tick();
      if (j < 6 && x == rx[j]) begin
        n_tests++;
        if ({if_m.r, if_m.g, if_m.b} !== {rv[j], rv[j], rv[j]}) begin
          n_fail++; $display("FAIL ramp x=%0d: got %b want %b", x, {if_m.r, if_m.g, if_m.b}, {rv[j], rv[j], rv[j]});
        end
        j++;
      end
    end
  endtask

  task automatic test_reset_midline();
    bit ok;
    bit ok2;
    int bad = 0;
    if_m.mode = 3'd1;
    do_reset();
    wait_fs(0, 4, ok);
    wait_fs(0, M_FRAME + 4, ok2);
    repeat (5) tick();
    n_tests++;
    if (!(ok && ok2) || if_m.display_en !== 1'b1 || {if_m.r, if_m.g, if_m.b} !== 6'b111111) begin
      n_fail++; $display("FAIL midline_pre: got de=%b rgb=%b want de=1 rgb=111111", if_m.display_en, {if_m.r, if_m.g, if_m.b});
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({if_m.r, if_m.g, if_m.b} !== 6'd0 || if_m.display_en !== 1'b0 || if_m.led !== 1'b0) begin
      n_fail++; $display("FAIL midline_async: got rgb=%b de=%b led=%b want 000000 0 0", {if_m.r, if_m.g, if_m.b}, if_m.display_en, if_m.led);
    end
    n_tests++;
    if (if_m.h_sync !== 1'b1 || if_m.v_sync !== 1'b1 || if_s.h_sync !== 1'b0 || if_s.v_sync !== 1'b0) begin
      n_fail++; $display("FAIL midline_sync: got m=%b%b s=%b%b want m=11 s=00", if_m.h_sync, if_m.v_sync, if_s.h_sync, if_s.v_sync);
    end
    @(negedge clk_in);
    reset = 1'b1;
    tick();
    n_tests++;
    if (if_m.frame_start !== 1'b1 || if_m.display_en !== 1'b1 || {if_m.r, if_m.g, if_m.b} !== 6'd0) begin
      n_fail++; $display("FAIL midline_release: got fs=%b de=%b rgb=%b want 1 1 000000", if_m.frame_start, if_m.display_en, {if_m.r, if_m.g, if_m.b});
    end
    ok = 1'b0;
    for (int i = 0; i < M_FRAME + 4 && !ok; i++) begin
      tick();
      if (if_m.frame_start === 1'b1) ok = 1'b1;
      else if ({if_m.r, if_m.g, if_m.b} !== 6'd0) bad++;
    end
    n_tests++;
    if (!ok || bad != 0) begin n_fail++; $display("FAIL midline_black_frame: got ok=%b bad=%0d want ok=1 bad=0", ok, bad); end
    n_tests++;
    if ({if_m.r, if_m.g, if_m.b} !== 6'b111111) begin n_fail++; $display("FAIL midline_next_white: got %b want 111111", {if_m.r, if_m.g, if_m.b}); end
  endtask

  task automatic scan_t(output int first, output int cnt);
    first = -1;
    cnt = 0;
    for (int x = 0; x < 24; x++) begin
      if (x > 0) tick();
      if ({if_t.r, if_t.g, if_t.b} === 6'b111111) begin
        if (first < 0) first = x;
        cnt++;
      end
    end
  endtask

  task automatic test_mode5();
    int ck [10];
    int ef [10];
    int ec [10];
    int j = 0;
    int n_to = 0;
    int first;
    int cnt;
    bit ok;
    ck = '{1, 2, 3, 5, 6, 100, 160, 255, 256, 257};
    ef = '{4, 8, 12, 20, -1, -1, -1, -1, 0, 4};
    ec = '{16, 16, 12, 4, 0, 0, 0, 0, 16, 16};
    if_t.mode = 3'd5;
    do_reset();
    tick();
    scan_t(first, cnt);
    n_tests++;
    if (if_t.display_en !== 1'b1 || cnt != 0) begin n_fail++; $display("FAIL bar_frame0: got de=%b cnt=%0d want de=1 cnt=0", if_t.display_en, cnt); end
    for (int k = 1; k <= 257; k++) begin
      wait_fs(2, 2 * T_FRAME, ok);
      if (!ok) n_to++;
      scan_t(first, cnt);
      if (j < 10 && k == ck[j]) begin
        n_tests++;
        if (first != ef[j] || cnt != ec[j]) begin
          n_fail++; $display("FAIL bar frame=%0d: got start=%0d width=%0d want start=%0d width=%0d", k, first, cnt, ef[j], ec[j]);
        end
        j++;
      end
    end
    n_tests++;
    if (n_to != 0) begin n_fail++; $display("FAIL bar_timeouts: got %0d want 0", n_to); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if_m.mode = 3'd0;
    if_s.mode = 3'd0;
    if_t.mode = 3'd0;
    test_reset();
    test_timing_small();
    test_last_cycle();
    test_color_bars();
    test_mode_switch();
    test_reset_midline();
    test_mode5();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
